// File: rtl/mux_arbiter_if.sv
// Bus bundle between upstream channels, the arbiter and the downstream consumer.
interface mux_arbiter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 4
);
  localparam int unsigned SELW = (NCH <= 2) ? 1 : $clog2(NCH);

  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [SELW-1:0]      sel;
  logic                 mode;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_chan;
  logic                 out_valid;
  logic                 out_ready;

  // Environment side: offers channel words, picks mode/sel, consumes output.
  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  // Arbiter side.
  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/mux_arbiter.sv
// N-channel valid/ready multiplexer with forced-select and round-robin modes
// feeding a single registered output stage.
module mux_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 4
) (
  input logic          Clk,
  input logic          Rst,
  mux_arbiter_if.slave bus
);

  localparam int unsigned SELW = (NCH <= 2) ? 1 : $clog2(NCH);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

  logic             grant_vld;
  logic [SELW-1:0]  grant_idx;
  logic             load_en;
  logic             xfer_in;
  int unsigned      idx;

  // Grant selection: forced channel in mode 0, rotating priority from rr_ptr in mode 1.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    if (bus.mode) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        idx = 32'(rr_ptr_q) + k;
        if (idx >= NCH) idx = idx - NCH;
        if (!grant_vld && bus.in_valid[SELW'(idx)]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(idx);
        end
      end
    end else if (32'(bus.sel) < NCH) begin
      grant_vld = bus.in_valid[bus.sel];
      grant_idx = bus.sel;
    end
  end

  // Output register may load when empty or being drained this cycle; reset blocks acceptance.
  always_comb begin
    load_en      = !out_valid_q || bus.out_ready;
    xfer_in      = grant_vld && load_en && !Rst;
    bus.in_ready = xfer_in ? (NCH'(1) << grant_idx) : '0;
  end

  // Next-state for the output stage and the round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer_in) begin
      out_data_d  = bus.in_data[grant_idx*WIDTH +: WIDTH];
      out_chan_d  = grant_idx;
      out_valid_d = 1'b1;
      if (bus.mode) begin
        rr_ptr_d = (grant_idx == SELW'(NCH - 1)) ? '0 : grant_idx + SELW'(1);
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset that discards any held word.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // Outputs come straight from the registers.
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = out_valid_q;

endmodule
